// File: rtl/fifo_4x16.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_4x16
//  Description : Single-clock synchronous FIFO with registered read data,
//                occupancy count and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_4x16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_accept;
    logic               w_rd_accept;
    logic [c_cnt_w-1:0] w_count_nxt;

    // Status is decoded purely from the registered count, so the request
    // inputs never reach full/empty/count combinationally.
    assign w_full      = (r_count == c_full_cnt);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = wr_en && !w_full;
    assign w_rd_accept = rd_en && !w_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage has no reset; the pointers reset instead, which hides stale words.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_4x16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_4x16
//  Description : Directed self-checking bench for fifo_4x16 with a queue
//                scoreboard and a small occupancy/flag reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_4x16;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        underflow;

    int          n_vec = 0;
    int          n_err = 0;

    logic [15:0] sb_q[$];
    int          mdl_cnt;
    logic [15:0] mdl_rd;
    logic        mdl_ovf;
    logic        mdl_unf;

    fifo_4x16 #(.WIDTH(16), .DEPTH(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(count),     32'(mdl_cnt));
        check({tag, ".full"},      32'(full),      32'(mdl_cnt == 4));
        check({tag, ".empty"},     32'(empty),     32'(mdl_cnt == 0));
        check({tag, ".rd_data"},   32'(rd_data),   32'(mdl_rd));
        check({tag, ".overflow"},  32'(overflow),  32'(mdl_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(mdl_unf));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clocked operation; the model decides acceptance from its own count.
    task automatic op(input string tag, input logic w, input logic [15:0] d, input logic r);
        logic wa;
        logic ra;
        wa = w && (mdl_cnt < 4);
        ra = r && (mdl_cnt > 0);
        if (w && mdl_cnt == 4) mdl_ovf = 1'b1;
        if (r && mdl_cnt == 0) mdl_unf = 1'b1;
        if (ra) mdl_rd = sb_q.pop_front();
        if (wa) sb_q.push_back(d);
        if (wa && !ra) mdl_cnt++;
        if (ra && !wa) mdl_cnt--;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input logic w, input logic [15:0] d);
        rst_n   = 1'b0;
        wr_en   = w;
        wr_data = d;
        rd_en   = w;
        tick();
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        sb_q.delete();
        mdl_cnt = 0;
        mdl_rd  = 16'h0000;
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        rd_en   = 1'b0;
        tick();
        do_reset(1'b0, 16'h0000);
        tick();
        check_all("reset_idle");

        // Fill to full, then drain in order
        op("wr1", 1'b1, 16'h1111, 1'b0);
        op("wr2", 1'b1, 16'h2222, 1'b0);
        op("wr3", 1'b1, 16'h3333, 1'b0);
        op("wr4", 1'b1, 16'h4444, 1'b0);
        for (int i = 0; i < 4; i++) op("drain", 1'b0, 16'h0000, 1'b1);

        // Overflow: write while full is dropped
        for (int i = 0; i < 4; i++) op("fill", 1'b1, 16'hA000 + 16'(i), 1'b0);
        op("ovf_wr", 1'b1, 16'hDEAD, 1'b0);
        op("full_wr_rd", 1'b1, 16'hDEAD, 1'b1);
        for (int i = 0; i < 3; i++) op("ovf_drain", 1'b0, 16'h0000, 1'b1);

        // Underflow: read while empty holds rd_data
        op("unf_rd", 1'b0, 16'h0000, 1'b1);
        op("empty_wr_rd", 1'b1, 16'hBEEF, 1'b1);
        op("rd_beef", 1'b0, 16'h0000, 1'b1);

        // Ten words streamed at occupancy two across several pointer wraps
        op("wrap_w0", 1'b1, 16'h0000, 1'b0);
        op("wrap_w1", 1'b1, 16'h0001, 1'b0);
        for (int k = 2; k < 10; k++) op("wrap_pair", 1'b1, 16'(k), 1'b1);
        op("wrap_r8", 1'b0, 16'h0000, 1'b1);
        op("wrap_r9", 1'b0, 16'h0000, 1'b1);

        // Mid-operation reset with a concurrent write request
        for (int i = 0; i < 3; i++) op("pre_rst", 1'b1, 16'hC000 + 16'(i), 1'b0);
        do_reset(1'b1, 16'h0BAD);
        check_all("mid_reset");
        op("post_rst_wr", 1'b1, 16'h5555, 1'b0);
        op("post_rst_rd", 1'b0, 16'h0000, 1'b1);

        // Reset pulse entirely between edges is ignored
        op("glitch_wr", 1'b1, 16'h6666, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check_all("glitch");
        op("glitch_rd", 1'b0, 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_4x16.md
FIFO_4X16 -- requirements
Module: fifo_4x16

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 4, number of storage entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-005 wr_en  input  1  write request from the producer.
REQ-006 wr_data  input  WIDTH  word to store when the write is accepted.
REQ-007 rd_en  input  1  read request from the consumer.
REQ-008 rd_data  output  WIDTH  registered word from the last accepted read.
REQ-009 full  output  1  high when count == DEPTH.
REQ-010 empty  output  1  high when count == 0.
REQ-011 count  output  log2(DEPTH)+1  number of words currently stored.
REQ-012 overflow  output  1  sticky; set by a write request while full.
REQ-013 underflow  output  1  sticky; set by a read request while empty.

Function
REQ-014 Storage shall be DEPTH x WIDTH registers, with a write pointer and a read pointer of log2(DEPTH) bits each, both wrapping modulo DEPTH.
REQ-015 A write shall be accepted iff wr_en=1 and full=0 at the rising edge; mem[wr_ptr] <= wr_data, wr_ptr <= wr_ptr+1.
REQ-016 A read shall be accepted iff rd_en=1 and empty=0 at the rising edge; rd_data <= mem[rd_ptr], rd_ptr <= rd_ptr+1.
REQ-017 Read latency shall be one cycle: rd_data carries the word on the edge that accepts the read and holds it until the next accepted read.
REQ-018 count shall update on the same edge: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-019 full, empty and count shall be registered or decoded from registered state only, with no combinational path from wr_en or rd_en.
REQ-020 Full with wr_en=1 and rd_en=1: the read is accepted, the write is rejected, count goes DEPTH -> DEPTH-1, and overflow is set.
REQ-021 Empty with wr_en=1 and rd_en=1: the write is accepted, the read is rejected, count goes 0 -> 1, rd_data is unchanged, and underflow is set.
REQ-022 Partially filled (0 < count < DEPTH) with wr_en=1 and rd_en=1: both are accepted and count is unchanged.
REQ-023 A rejected write shall not modify storage or wr_ptr; a rejected read shall not modify rd_data or rd_ptr.
REQ-024 overflow and underflow shall stay set until reset.
REQ-025 Words shall emerge in write order across any number of pointer wraps.

Reset
REQ-026 On any rising clk with rst_n=0: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, overflow=0, underflow=0.
REQ-027 Reset shall take priority over simultaneous wr_en and rd_en; neither is accepted in that cycle.
REQ-028 Storage contents need not be cleared; after reset they shall be unobservable until rewritten.
REQ-029 Reset asserted mid-operation (for example count=3) shall empty the FIFO within that single edge; the first read after release shall return the first word written after release.
REQ-030 rst_n changing between edges shall have no effect on outputs (synchronous reset).

Verification
REQ-031 Reset then idle -> empty=1, full=0, count=0, rd_data=0x0000, overflow=0, underflow=0.
REQ-032 Write 0x1111, 0x2222, 0x3333, 0x4444, then 4 reads -> full=1 after the 4th write; rd_data is 0x1111, 0x2222, 0x3333, 0x4444 on successive read edges; then empty=1.
REQ-033 While full, write 0xDEAD -> overflow=1, count=4, and subsequent reads never return 0xDEAD.
REQ-034 While empty, read -> underflow=1 and rd_data holds its previous value; then simultaneous wr 0xBEEF and rd -> count=1, and the next read returns 0xBEEF.
REQ-035 Ten write/read pairs with data 0x0000..0x0009, interleaved to force wrap at count=2 -> output order 0x0000..0x0009, count returns to 0.
REQ-036 At count=3, assert rst_n=0 for one edge together with wr_en=1 -> count=0, empty=1, and the write is not stored.
